uart_rx_fifo: RTL

// Downstream of the UART receiver. Takes each byte the receiver flags with rdy/data and

---
 rtl/uart_rx_fifo_pkg.sv | 8 +
 rtl/uart_rx_fifo_if.sv | 28 ++
 rtl/uart_fifo_mem.sv | 31 +++
 rtl/uart_rx_fifo.sv | 92 +++++++++
 4 files changed

// File: rtl/uart_rx_fifo_pkg.sv
// Shared UART buffer definitions: data width, default FIFO depth and the byte type.
// Used by uart_rx_fifo, its stream interface and the storage sub-module.
package uart_rx_fifo_pkg;
  localparam int UART_DATA_W        = 8;
  localparam int UART_RX_FIFO_DEPTH = 16;

  typedef logic [UART_DATA_W-1:0] byte_t;
endpackage

// File: rtl/uart_rx_fifo_if.sv
// Receiver-side handshake, consumer stream and status signals of uart_rx_fifo.
// slave = the FIFO, master = whatever drives the receiver side and consumes the stream.
interface uart_rx_fifo_if
  import uart_rx_fifo_pkg::*;
#(
  parameter int AW = 4
);
  byte_t         rx_data;
  logic          rx_rdy;
  logic          rx_clr;
  byte_t         m_data;
  logic          m_valid;
  logic          m_ready;
  logic [AW:0]   count;
  logic          full;
  logic          ovf;
  logic          ovf_clr;

  modport slave (
    input  rx_data, rx_rdy, m_ready, ovf_clr,
    output rx_clr, m_data, m_valid, count, full, ovf
  );

  modport master (
    output rx_data, rx_rdy, m_ready, ovf_clr,
    input  rx_clr, m_data, m_valid, count, full, ovf
  );
endinterface

// File: rtl/uart_fifo_mem.sv
// DEPTH x byte storage with one write port and a registered read port.
// The read register is reset so the head byte reads 8'h00 out of reset.
module uart_fifo_mem
  import uart_rx_fifo_pkg::*;
#(
  parameter int DEPTH = UART_RX_FIFO_DEPTH,
  parameter int AW    = $clog2(DEPTH)
) (
  input  logic          clk_50m,
  input  logic          rst_n,
  input  logic          i_we,
  input  logic [AW-1:0] i_wr_addr,
  input  byte_t         i_wr_data,
  input  logic [AW-1:0] i_rd_addr,
  output byte_t         o_rd_data
);
  byte_t r_mem [DEPTH];
  byte_t r_rd_data;

  // NOTE: storage has no reset so it maps onto plain RAM; only the read register is cleared.
  always_ff @(posedge clk_50m) begin
    if (i_we) r_mem[i_wr_addr] <= i_wr_data;
  end

  always_ff @(posedge clk_50m) begin
    if (!rst_n) r_rd_data <= '0;
    else        r_rd_data <= r_mem[i_rd_addr];
  end

  assign o_rd_data = r_rd_data;
endmodule

// File: rtl/uart_rx_fifo.sv
// Receiver-side byte capture/ack plus show-ahead FIFO onto a valid/ready stream.
// Define UART_RX_FIFO_OVF_EN to enable the sticky overflow flag; otherwise ovf is tied 0.
module uart_rx_fifo
  import uart_rx_fifo_pkg::*;
#(
  parameter int DEPTH = UART_RX_FIFO_DEPTH,
  parameter int AW    = $clog2(DEPTH)
) (
  input  logic           clk_50m,
  input  logic           rst_n,
  uart_rx_fifo_if.slave  bus
);
  logic          r_clr;
  logic          r_valid;
  logic [AW-1:0] r_wr_ptr;
  logic [AW-1:0] r_rd_ptr;
  logic [AW:0]   r_count;

  logic          w_take;
  logic          w_full;
  logic          w_pop;
  logic          w_push;
  logic [AW-1:0] w_rd_addr;
  logic [AW:0]   w_remain;
  byte_t         w_rd_data;

  assign w_take    = bus.rx_rdy && !r_clr;
  assign w_full    = (r_count == (AW+1)'(DEPTH));
  assign w_pop     = r_valid && bus.m_ready;
  assign w_push    = w_take && (!w_full || w_pop);
  assign w_rd_addr = r_rd_ptr + AW'(w_pop);
  // Entries already in storage behind the head; a byte written this edge is not yet readable.
  assign w_remain  = r_count - (AW+1)'(w_pop);

  // NOTE: all state updates use non-blocking assignments so every register sees pre-edge values.
  always_ff @(posedge clk_50m) begin
    if (!rst_n) begin
      r_clr    <= 1'b0;
      r_valid  <= 1'b0;
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_count  <= '0;
    end else begin
      r_clr <= w_take;
      if (w_push) r_wr_ptr <= r_wr_ptr + AW'(1);
      if (w_pop)  r_rd_ptr <= w_rd_addr;
      case ({w_push, w_pop})
        2'b10:   r_count <= r_count + (AW+1)'(1);
        2'b01:   r_count <= r_count - (AW+1)'(1);
        default: r_count <= r_count;
      endcase
      r_valid <= (w_remain != '0);
    end
  end

  uart_fifo_mem #(
    .DEPTH (DEPTH),
    .AW    (AW)
  ) u_mem (
    .clk_50m   (clk_50m),
    .rst_n     (rst_n),
    .i_we      (w_push),
    .i_wr_addr (r_wr_ptr),
    .i_wr_data (bus.rx_data),
    .i_rd_addr (w_rd_addr),
    .o_rd_data (w_rd_data)
  );

`ifdef UART_RX_FIFO_OVF_EN
  logic w_ovf_evt;
  logic r_ovf;

  // A dropped byte: taken while full with no pop to make room. Set beats clear.
  assign w_ovf_evt = w_take && w_full && !w_pop;

  always_ff @(posedge clk_50m) begin
    if (!rst_n)           r_ovf <= 1'b0;
    else if (w_ovf_evt)   r_ovf <= 1'b1;
    else if (bus.ovf_clr) r_ovf <= 1'b0;
  end

  assign bus.ovf = r_ovf;
`else
  assign bus.ovf = 1'b0;
`endif

  assign bus.rx_clr  = r_clr;
  assign bus.m_data  = w_rd_data;
  assign bus.m_valid = r_valid;
  assign bus.count   = r_count;
  assign bus.full    = w_full;
endmodule
